// File: rtl/rom_dl_bridge_if.sv
// SDRAM write-port bundle for the ROM download bridge.
// Two toggle req/ack ports: port1 (CPU/sound ROM), port2 (sprites).
interface rom_dl_bridge_if;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;

    modport master (
        output port1_req, port1_a, port1_ds, port1_d,
        output port2_req, port2_a, port2_ds, port2_d,
        input  port1_ack, port2_ack
    );

    modport slave (
        input  port1_req, port1_a, port1_ds, port1_d,
        input  port2_req, port2_a, port2_ds, port2_d,
        output port1_ack, port2_ack
    );
endinterface

// File: rtl/rom_dl_bridge.sv
// ROM download bridge: buffers hps_io ioctl bytes in a FIFO and writes
// them to SDRAM port1 (all ROM) and port2 (sprite range, remapped).
// Ports: clk_mem/reset_n, ioctl_* download inputs, ioctl_wait,
// sdram (port1/port2 toggle handshakes), dip_sw0/1, busy, dl_done, overflow.
module rom_dl_bridge #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = 25'h10000,
    parameter logic [24:0] SP_END     = 25'h1BFFF
) (
    input  logic        clk_mem,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    rom_dl_bridge_if.master sdram,
    output logic [7:0]  dip_sw0,
    output logic [7:0]  dip_sw1,
    output logic        busy,
    output logic        dl_done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [32:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           wr_q;
    logic           p2_issued;

    logic           wr_rise, push_req, push, pop;
    logic           full, empty, dip_hit, acks_ok, busy_c;
    logic [24:0]    head_a;
    logic [7:0]     head_d;
    logic [23:0]    sp_off;
    logic           in_sp;

    assign wr_rise  = ioctl_wr & ~wr_q;
    assign push_req = wr_rise & ioctl_download & (ioctl_index == 8'd0);
    assign dip_hit  = wr_rise & (ioctl_index == 8'd254)
                    & (ioctl_addr[24:3] == 22'd0);

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A same-cycle pop frees the slot, so a push into a full FIFO is fine.
    assign push = push_req & (~full | pop);

    assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));

    assign head_a = mem[rd_ptr][32:8];
    assign head_d = mem[rd_ptr][7:0];
    // Only the low 24 bits of the offset feed the port2 address.
    assign sp_off = head_a[23:0] - SP_BASE[23:0];
    assign in_sp  = (head_a >= SP_BASE) && (head_a <= SP_END);

    assign acks_ok = (sdram.port1_ack == sdram.port1_req)
                   && (!p2_issued || (sdram.port2_ack == sdram.port2_req));

    assign busy_c = ioctl_download | ~empty | (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            SYNC: state_d = IDLE;
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (acks_ok) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) state_q <= SYNC;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_mem) begin
        if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            sdram.port1_req <= 1'b0;
            sdram.port1_a   <= '0;
            sdram.port1_ds  <= '0;
            sdram.port1_d   <= '0;
            sdram.port2_req <= 1'b0;
            sdram.port2_a   <= '0;
            sdram.port2_ds  <= '0;
            sdram.port2_d   <= '0;
            p2_issued       <= 1'b0;
        end else begin
            // Re-align req with whatever ack the SDRAM left behind.
            if (state_q == SYNC) begin
                sdram.port1_req <= sdram.port1_ack;
                sdram.port2_req <= sdram.port2_ack;
            end
            if (pop) begin
                sdram.port1_a   <= head_a[23:1];
                sdram.port1_ds  <= {head_a[0], ~head_a[0]};
                sdram.port1_d   <= {head_d, head_d};
                sdram.port1_req <= ~sdram.port1_req;
                p2_issued       <= in_sp;
                if (in_sp) begin
                    sdram.port2_a   <= {sp_off[23:16], sp_off[13:0],
                                        sp_off[15]};
                    sdram.port2_ds  <= {sp_off[14], ~sp_off[14]};
                    sdram.port2_d   <= {head_d, head_d};
                    sdram.port2_req <= ~sdram.port2_req;
                end
            end
        end
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            wr_q     <= 1'b0;
            busy     <= 1'b0;
            dl_done  <= 1'b0;
            overflow <= 1'b0;
            dip_sw0  <= '0;
            dip_sw1  <= '0;
        end else begin
            wr_q    <= ioctl_wr;
            busy    <= busy_c;
            dl_done <= busy & ~busy_c;
            if (push_req && full && !pop) overflow <= 1'b1;
            if (dip_hit && ioctl_addr[2:0] == 3'd0) dip_sw0 <= ioctl_dout;
            if (dip_hit && ioctl_addr[2:0] == 3'd1) dip_sw1 <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Randomised bench for rom_dl_bridge with a queue-based reference model.
// Ports driven: ioctl_* stimulus, SDRAM ack responders with variable delay.
module tb_rom_dl_bridge;
    localparam int D = 4;
    localparam logic [24:0] SPB = 25'h10000;
    localparam logic [24:0] SPE = 25'h1BFFF;

    logic        clk_mem = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [7:0]  dip_sw0, dip_sw1;
    logic        busy, dl_done, overflow;

    rom_dl_bridge_if sd ();

    rom_dl_bridge #(.FIFO_DEPTH(D), .SP_BASE(SPB), .SP_END(SPE)) dut (
        .clk_mem(clk_mem),
        .reset_n(reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait),
        .sdram(sd),
        .dip_sw0(dip_sw0),
        .dip_sw1(dip_sw1),
        .busy(busy),
        .dl_done(dl_done),
        .overflow(overflow)
    );

    always #5 clk_mem = ~clk_mem;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [32:0] fifo_q[$];
    bit          m_ovf = 0;
    logic [7:0]  m_sw0 = 0, m_sw1 = 0;
    bit          prev_wr = 0;
    bit          sync_pend = 1;
    int          n_wr1 = 0, n_wr2 = 0, n_done = 0, n_push = 0;
    logic [22:0] l1a = 0, l2a = 0;
    logic [1:0]  l1ds = 0, l2ds = 0;
    logic [15:0] l1d = 0, l2d = 0;

    function automatic bit in_sprite(input logic [24:0] a);
        return (a >= SPB) && (a <= SPE);
    endfunction

    function automatic logic [22:0] p2a_of(input logic [24:0] a);
        int unsigned s;
        s = (32'(a) - 32'(SPB)) & 32'h1FF_FFFF;
        return 23'((((s >> 16) & 32'hFF) << 15) | ((s & 32'h3FFF) << 1)
                   | ((s >> 15) & 32'h1));
    endfunction

    function automatic logic [1:0] p2ds_of(input logic [24:0] a);
        int unsigned s;
        s = (32'(a) - 32'(SPB)) & 32'h1FF_FFFF;
        return ((s >> 14) & 1) != 0 ? 2'b10 : 2'b01;
    endfunction

    always begin
        logic        wr, dl, r1, r2, a1, a2, w, issync, rise, t1, t2;
        logic [7:0]  idx, dout;
        logic [24:0] addr;
        logic [32:0] e;
        int          sz;
        @(posedge clk_mem);
        if (!reset_n) begin
            fifo_q.delete();
            m_ovf = 0; m_sw0 = 0; m_sw1 = 0;
            prev_wr = 0; sync_pend = 1;
        end else begin
            wr = ioctl_wr; dl = ioctl_download; idx = ioctl_index;
            addr = ioctl_addr; dout = ioctl_dout;
            r1 = sd.port1_req; r2 = sd.port2_req;
            a1 = sd.port1_ack; a2 = sd.port2_ack;
            w = ioctl_wait; sz = fifo_q.size();
            issync = sync_pend; sync_pend = 0;
            #1;
            if (reset_n) begin
                chk("ioctl_wait", 32'(w), 32'(sz >= D - 1));
                rise = wr && !prev_wr;
                prev_wr = wr;
                t1 = sd.port1_req != r1;
                t2 = sd.port2_req != r2;
                if (issync) begin
                    chk("sync_req1", 32'(sd.port1_req), 32'(sd.port1_ack));
                    chk("sync_req2", 32'(sd.port2_req), 32'(sd.port2_ack));
                end else if (t1) begin
                    chk("pop_nonempty", 32'(sz > 0), 1);
                    chk("ack_before_pop", 32'((r1 == a1) && (r2 == a2)), 1);
                    if (sz > 0) begin
                        e = fifo_q.pop_front();
                        n_wr1++;
                        chk("p1_a", 32'(sd.port1_a), 32'(e[31:9]));
                        chk("p1_ds", 32'(sd.port1_ds),
                            e[8] ? 32'h2 : 32'h1);
                        chk("p1_d", 32'(sd.port1_d), 32'({e[7:0], e[7:0]}));
                        chk("p2_issue", 32'(t2), 32'(in_sprite(e[32:8])));
                        if (t2) begin
                            n_wr2++;
                            chk("p2_a", 32'(sd.port2_a), 32'(p2a_of(e[32:8])));
                            chk("p2_ds", 32'(sd.port2_ds),
                                32'(p2ds_of(e[32:8])));
                            chk("p2_d", 32'(sd.port2_d),
                                32'({e[7:0], e[7:0]}));
                        end
                    end
                end else begin
                    chk("p2_stray", 32'(t2), 0);
                    if (sd.port1_req != sd.port1_ack) begin
                        chk("p1_a_hold", 32'(sd.port1_a), 32'(l1a));
                        chk("p1_d_hold", 32'(sd.port1_d), 32'(l1d));
                    end
                    if (sd.port2_req != sd.port2_ack)
                        chk("p2_a_hold", 32'(sd.port2_a), 32'(l2a));
                end
                l1a = sd.port1_a; l1ds = sd.port1_ds; l1d = sd.port1_d;
                l2a = sd.port2_a; l2ds = sd.port2_ds; l2d = sd.port2_d;
                if (rise && dl && idx == 8'd0) begin
                    if (sz < D || (t1 && !issync)) begin
                        fifo_q.push_back({addr, dout});
                        n_push++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (rise && idx == 8'd254 && addr[24:3] == 22'd0) begin
                    if (addr[2:0] == 3'd0) m_sw0 = dout;
                    if (addr[2:0] == 3'd1) m_sw1 = dout;
                end
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("dip_sw0", 32'(dip_sw0), 32'(m_sw0));
                chk("dip_sw1", 32'(dip_sw1), 32'(m_sw1));
                if (dl_done) n_done++;
            end
        end
    end

    // ---------------- SDRAM ack responders ----------------
    int dly1 = 0, dly2 = 0;
    bit hold = 0;

    initial begin
        sd.port1_ack = 1'b0;
        sd.port2_ack = 1'b0;
    end

    always begin
        @(posedge clk_mem); #3;
        if (!hold && reset_n && sd.port1_req !== sd.port1_ack) begin
            repeat (dly1) @(posedge clk_mem);
            if (dly1 > 0) #3;
            if (!hold && reset_n) sd.port1_ack = sd.port1_req;
        end
    end

    always begin
        @(posedge clk_mem); #3;
        if (!hold && reset_n && sd.port2_req !== sd.port2_ack) begin
            repeat (dly2) @(posedge clk_mem);
            if (dly2 > 0) #3;
            if (!hold && reset_n) sd.port2_ack = sd.port2_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_mem);
            #2;
        end
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d,
                          input logic [7:0] idx, input int len,
                          input bit obey);
        int b;
        b = 0;
        if (obey) begin
            while (ioctl_wait && b < 500) begin
                cyc(1);
                b++;
            end
            chk("wait_bound", 32'(b >= 500), 0);
        end
        ioctl_addr = a; ioctl_dout = d; ioctl_index = idx;
        ioctl_wr = 1'b1;
        cyc(len);
        ioctl_wr = 1'b0;
        cyc(1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((busy || fifo_q.size() != 0 ||
                sd.port1_req !== sd.port1_ack ||
                sd.port2_req !== sd.port2_ack) && b < 3000) begin
            cyc(1);
            b++;
        end
        chk("drain_bound", 32'(b >= 3000), 0);
        cyc(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, dn;
        logic [24:0] edge_addr [6];
        edge_addr[0] = 25'h0FFFF; edge_addr[1] = 25'h10000;
        edge_addr[2] = 25'h1BFFF; edge_addr[3] = 25'h1C000;
        edge_addr[4] = 25'h1000007; edge_addr[5] = 25'h1010000;

        cyc(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req1", 32'(sd.port1_req), 0);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(dl_done), 0);
        reset_n = 1'b1;
        cyc(3);

        // single ROM byte
        w1 = n_wr1; w2 = n_wr2; dn = n_done;
        ioctl_download = 1'b1;
        strobe(25'h00003, 8'hA5, 8'd0, 1, 1);
        cyc(3);
        ioctl_download = 1'b0;
        drain();
        chk("single_a", 32'(l1a), 32'h000001);
        chk("single_ds", 32'(l1ds), 32'h2);
        chk("single_d", 32'(l1d), 32'hA5A5);
        chk("single_n1", 32'(n_wr1 - w1), 1);
        chk("single_n2", 32'(n_wr2 - w2), 0);
        chk("single_done", 32'(n_done - dn), 1);

        // sprite byte with slow port2 ack
        w2 = n_wr2; dly2 = 6;
        ioctl_download = 1'b1;
        strobe(25'h14005, 8'h3C, 8'd0, 1, 1);
        strobe(25'h00010, 8'h99, 8'd0, 1, 1);
        ioctl_download = 1'b0;
        drain();
        chk("sprite_n2", 32'(n_wr2 - w2), 1);
        chk("sprite_a2", 32'(l2a), 32'h00000A);
        chk("sprite_ds2", 32'(l2ds), 32'h2);
        chk("sprite_d2", 32'(l2d), 32'h3C3C);
        dly2 = 0;

        // back-pressure ignored: sixth byte dropped
        w1 = n_wr1; dly1 = 20;
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++)
            strobe(25'h100 + 25'(i), 8'(i + 1), 8'd0, 1, 0);
        chk("bp_wait", 32'(ioctl_wait), 1);
        chk("bp_ovf", 32'(overflow), 1);
        ioctl_download = 1'b0;
        drain();
        chk("bp_writes", 32'(n_wr1 - w1), 5);
        dly1 = 0;

        // DIP capture
        w1 = n_wr1;
        ioctl_download = 1'b1;
        strobe(25'd0, 8'h12, 8'd254, 1, 1);
        strobe(25'd1, 8'h34, 8'd254, 1, 1);
        strobe(25'd2, 8'hFF, 8'd254, 1, 1);
        strobe(25'd8, 8'h55, 8'd254, 1, 1);
        ioctl_download = 1'b0;
        drain();
        chk("dip0", 32'(dip_sw0), 32'h12);
        chk("dip1", 32'(dip_sw1), 32'h34);
        chk("dip_writes", 32'(n_wr1 - w1), 0);

        // long strobe
        w1 = n_wr1;
        ioctl_download = 1'b1;
        strobe(25'h200, 8'h5A, 8'd0, 4, 1);
        ioctl_download = 1'b0;
        drain();
        chk("long_writes", 32'(n_wr1 - w1), 1);
        chk("long_d", 32'(l1d), 32'h5A5A);

        // reset while waiting on a stale ack
        ioctl_download = 1'b1;
        if (sd.port1_req) begin
            strobe(25'h400, 8'h01, 8'd0, 1, 1);
            cyc(6);
        end
        hold = 1;
        strobe(25'h300, 8'h11, 8'd0, 1, 1);
        cyc(3);
        chk("pre_rst_pending", 32'(sd.port1_req ^ sd.port1_ack), 1);
        ioctl_download = 1'b0;
        reset_n = 1'b0;
        sd.port1_ack = 1'b1;
        cyc(2);
        chk("in_rst_req1", 32'(sd.port1_req), 0);
        reset_n = 1'b1;
        w1 = n_wr1;
        cyc(3);
        chk("post_rst_req1", 32'(sd.port1_req), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_wait", 32'(ioctl_wait), 0);
        chk("post_rst_ovf", 32'(overflow), 0);
        cyc(10);
        chk("post_rst_writes", 32'(n_wr1 - w1), 0);
        hold = 0;

        // randomised traffic, range edges first
        w1 = n_wr1; w2 = n_push; dn = n_done;
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++)
            strobe(edge_addr[i], 8'($urandom), 8'd0, 1, 1);
        for (int i = 0; i < 150; i++) begin
            logic [24:0] a;
            logic [7:0]  ix;
            dly1 = $urandom_range(0, 4);
            dly2 = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0: a = 25'($urandom);
                1: a = 25'(32'h0FFF0 + $urandom_range(0, 32));
                2: a = 25'(32'h1BFF0 + $urandom_range(0, 32));
                default: a = 25'($urandom_range(0, 32'h1FFFF));
            endcase
            ix = ($urandom_range(0, 9) == 0) ? 8'd254 : 8'd0;
            if (ix == 8'd254) a = 25'($urandom_range(0, 9));
            strobe(a, 8'($urandom), ix, $urandom_range(1, 3),
                   $urandom_range(0, 7) != 0);
            cyc($urandom_range(0, 2));
        end
        ioctl_download = 1'b0;
        drain();
        chk("rand_all_issued", 32'(n_wr1 - w1), 32'(n_push - w2));
        chk("rand_done", 32'(n_done - dn), 1);
        chk("rand_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
